// File: rtl/wb_pc_ctrl.sv
// Writeback and program-flow controller: owns the 8-entry register file, the pc,
// load completion over the data-memory read handshake and jump flush generation.
module wb_pc_ctrl #(
    parameter int A_BITS       = 10,
    parameter int D_BITS       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [D_BITS-1:0] in_result,
    input  logic [2:0]        in_dest,
    input  logic              in_halt_op,
    input  logic              in_jmp_op,
    input  logic              in_jmp_relative_op,
    input  logic [A_BITS-1:0] in_jmp_val,
    input  logic              in_read,
    input  logic              in_write_en,
    output logic              mem_rd_req,
    output logic [A_BITS-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [D_BITS-1:0] mem_rd_data,
    input  logic [2:0]        rf_raddr_a,
    output logic [D_BITS-1:0] rf_rdata_a,
    input  logic [2:0]        rf_raddr_b,
    output logic [D_BITS-1:0] rf_rdata_b,
    output logic [A_BITS-1:0] pc,
    output logic              clr_sgn,
    output logic              stall,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH     = 2'd2;
    localparam logic [1:0] S_HALT      = 2'd3;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        flush_cnt;
    logic [2:0]        ld_dest;
    logic [D_BITS-1:0] rf [8];

    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [D_BITS-1:0] wr_data;

    // The one register-file write port: a RUN-state write or a load completion.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = in_dest;
        wr_data = in_result;
        case (state)
            S_RUN: begin
                if (!in_halt_op) begin
                    if (in_jmp_op) wr_en = in_write_en;
                    else           wr_en = in_write_en & ~in_read;
                end
            end
            S_LOAD_WAIT: begin
                if (mem_rd_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = ld_dest;
                    wr_data = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    assign rf_rdata_a = (wr_en && wr_idx == rf_raddr_a) ? wr_data : rf[rf_raddr_a];
    assign rf_rdata_b = (wr_en && wr_idx == rf_raddr_b) ? wr_data : rf[rf_raddr_b];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wr_idx] <= wr_data;
        end
    end

    // Read handshake: mem_rd_req/mem_rd_addr stay stable from the load edge until
    // the first rising edge where mem_rd_valid is sampled high; that edge completes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_RUN;
            pc          <= '0;
            flush_cnt   <= '0;
            ld_dest     <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (in_halt_op) begin
                        state <= S_HALT;
                    end else if (in_jmp_op) begin
                        pc        <= in_jmp_relative_op ? pc + in_jmp_val : in_jmp_val;
                        flush_cnt <= FLUSH_INIT;
                        state     <= S_FLUSH;
                    end else if (in_read && in_write_en) begin
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= in_result[A_BITS-1:0];
                        ld_dest     <= in_dest;
                        state       <= S_LOAD_WAIT;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                S_LOAD_WAIT: begin
                    if (mem_rd_valid) begin
                        mem_rd_req <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == 4'd0) state <= S_RUN;
                    else                   flush_cnt <= flush_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign clr_sgn   = (state == S_FLUSH);
    assign stall     = (state == S_LOAD_WAIT);
    assign halted    = (state == S_HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_pc_ctrl.sv
// Self-checking bench for wb_pc_ctrl: directed scenarios with data expectations
// queued at stimulus time and popped when the DUT presents the result.
module tb_wb_pc_ctrl;

    localparam int A_BITS = 10;
    localparam int D_BITS = 32;

    logic              clk;
    logic              nrst;
    logic [D_BITS-1:0] in_result;
    logic [2:0]        in_dest;
    logic              in_halt_op;
    logic              in_jmp_op;
    logic              in_jmp_relative_op;
    logic [A_BITS-1:0] in_jmp_val;
    logic              in_read;
    logic              in_write_en;
    logic              mem_rd_req;
    logic [A_BITS-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [D_BITS-1:0] mem_rd_data;
    logic [2:0]        rf_raddr_a;
    logic [D_BITS-1:0] rf_rdata_a;
    logic [2:0]        rf_raddr_b;
    logic [D_BITS-1:0] rf_rdata_b;
    logic [A_BITS-1:0] pc;
    logic              clr_sgn;
    logic              stall;
    logic              halted;
    logic [1:0]        dbg_state;

    int n_checks;
    int n_errors;
    logic [D_BITS-1:0] exp_q[$];

    wb_pc_ctrl #(.A_BITS(A_BITS), .D_BITS(D_BITS), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .nrst(nrst),
        .in_result(in_result), .in_dest(in_dest), .in_halt_op(in_halt_op),
        .in_jmp_op(in_jmp_op), .in_jmp_relative_op(in_jmp_relative_op),
        .in_jmp_val(in_jmp_val), .in_read(in_read), .in_write_en(in_write_en),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .rf_raddr_a(rf_raddr_a), .rf_rdata_a(rf_rdata_a),
        .rf_raddr_b(rf_raddr_b), .rf_rdata_b(rf_rdata_b),
        .pc(pc), .clr_sgn(clr_sgn), .stall(stall), .halted(halted),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [D_BITS-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [D_BITS-1:0] obs);
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_result = '0; in_dest = '0; in_halt_op = 0; in_jmp_op = 0;
        in_jmp_relative_op = 0; in_jmp_val = '0; in_read = 0; in_write_en = 0;
        mem_rd_valid = 0; mem_rd_data = '0;
    endtask

    task automatic drive_write(input logic [2:0] d, input logic [D_BITS-1:0] v);
        in_dest = d; in_result = v; in_write_en = 1;
    endtask

    task automatic drive_load(input logic [2:0] d, input logic [D_BITS-1:0] a);
        in_dest = d; in_result = a; in_read = 1; in_write_en = 1;
    endtask

    task automatic drive_jump(input logic rel, input logic [A_BITS-1:0] v);
        in_jmp_op = 1; in_jmp_relative_op = rel; in_jmp_val = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rf_raddr_a = 3'd3;
        rf_raddr_b = 3'd0;
        nrst = 0;
        #3;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_clr", 32'(clr_sgn), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req", 32'(mem_rd_req), 32'd0);
        push_exp(32'd0);
        sb_check("rst_rf3", rf_rdata_a);
        #9 nrst = 1;

        // idle cycles advance pc
        repeat (5) step();
        check("idle_pc", 32'(pc), 32'd5);
        check("idle_clr", 32'(clr_sgn), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        push_exp(32'd0);
        sb_check("idle_rf3", rf_rdata_a);

        // write with same-cycle bypass
        drive_write(3'd3, 32'hDEADBEEF);
        #1;
        push_exp(32'hDEADBEEF);
        sb_check("bypass_a", rf_rdata_a);
        step();
        idle_inputs();
        push_exp(32'hDEADBEEF);
        sb_check("wr_rf3", rf_rdata_a);
        check("wr_pc", 32'(pc), 32'd6);

        // random-length idle to reach pc=20 in two chunks
        begin
            int n1;
            n1 = $urandom_range(1, 13);
            repeat (n1) step();
            repeat (14 - n1) step();
        end
        check("pre_jmp_pc", 32'(pc), 32'd20);

        // relative jump back by 4 with a write on the jump edge
        drive_jump(1'b1, 10'h3FC);
        drive_write(3'd6, 32'hA5A5A5A5);
        step();
        idle_inputs();
        check("rjmp_pc", 32'(pc), 32'd16);
        check("rjmp_clr1", 32'(clr_sgn), 32'd1);
        drive_write(3'd4, 32'h00001111);
        step();
        check("flush_clr2", 32'(clr_sgn), 32'd1);
        check("flush_pc2", 32'(pc), 32'd16);
        idle_inputs();
        step();
        check("flush_end_clr", 32'(clr_sgn), 32'd0);
        check("flush_end_pc", 32'(pc), 32'd16);
        rf_raddr_a = 3'd6;
        rf_raddr_b = 3'd4;
        #1;
        push_exp(32'hA5A5A5A5);
        sb_check("jmp_wr_rf6", rf_rdata_a);
        push_exp(32'd0);
        sb_check("flush_nowr_rf4", rf_rdata_b);
        step();
        check("post_flush_pc", 32'(pc), 32'd17);

        // load with 3-cycle latency; writes presented meanwhile are ignored
        drive_load(3'd5, 32'hFFFFF055);
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            check("ld_req", 32'(mem_rd_req), 32'd1);
            check("ld_addr", 32'(mem_rd_addr), 32'h055);
            check("ld_stall", 32'(stall), 32'd1);
            check("ld_pc", 32'(pc), 32'd17);
            if (c < 3) begin
                drive_write(3'd7, 32'h77);
                step();
                idle_inputs();
            end
        end
        rf_raddr_a = 3'd5;
        rf_raddr_b = 3'd7;
        mem_rd_valid = 1;
        mem_rd_data = 32'h12345678;
        #1;
        push_exp(32'h12345678);
        sb_check("ld_bypass", rf_rdata_a);
        step();
        idle_inputs();
        check("ld_done_req", 32'(mem_rd_req), 32'd0);
        check("ld_done_stall", 32'(stall), 32'd0);
        push_exp(32'h12345678);
        sb_check("ld_rf5", rf_rdata_a);
        push_exp(32'd0);
        sb_check("ld_nowr_rf7", rf_rdata_b);
        step();
        check("ld_resume_pc", 32'(pc), 32'd18);

        // single-cycle load; stray valid before it is ignored
        mem_rd_valid = 1;
        mem_rd_data = 32'hBAD0BAD0;
        step();
        idle_inputs();
        check("stray_valid_pc", 32'(pc), 32'd19);
        drive_load(3'd2, 32'h3A0);
        step();
        idle_inputs();
        check("ld1_addr", 32'(mem_rd_addr), 32'h3A0);
        mem_rd_valid = 1;
        mem_rd_data = 32'hCAFEF00D;
        step();
        idle_inputs();
        rf_raddr_a = 3'd2;
        #1;
        check("ld1_req", 32'(mem_rd_req), 32'd0);
        push_exp(32'hCAFEF00D);
        sb_check("ld1_rf2", rf_rdata_a);
        check("ld1_pc", 32'(pc), 32'd19);

        // halt wins over jump and freezes everything
        in_halt_op = 1;
        drive_jump(1'b0, 10'h100);
        step();
        idle_inputs();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_clr", 32'(clr_sgn), 32'd0);
        check("halt_pc", 32'(pc), 32'd19);
        repeat (10) begin
            drive_write(3'd2, $urandom_range(0, 1000));
            step();
        end
        idle_inputs();
        check("halt10_halted", 32'(halted), 32'd1);
        check("halt10_pc", 32'(pc), 32'd19);
        check("halt10_req", 32'(mem_rd_req), 32'd0);
        push_exp(32'hCAFEF00D);
        sb_check("halt10_rf2", rf_rdata_a);
        nrst = 0;
        #2;
        check("hrst_pc", 32'(pc), 32'd0);
        check("hrst_halted", 32'(halted), 32'd0);
        check("hrst_state", 32'(dbg_state), 32'd0);
        push_exp(32'd0);
        sb_check("hrst_rf2", rf_rdata_a);
        nrst = 1;

        // reset in the middle of a load
        step();
        drive_load(3'd1, 32'h011);
        step();
        idle_inputs();
        check("ld2_req", 32'(mem_rd_req), 32'd1);
        nrst = 0;
        #1;
        check("ld2_rst_req", 32'(mem_rd_req), 32'd0);
        check("ld2_rst_stall", 32'(stall), 32'd0);
        check("ld2_rst_state", 32'(dbg_state), 32'd0);
        nrst = 1;

        // absolute jump to the top address, then wrap
        step();
        drive_jump(1'b0, 10'h3FF);
        step();
        idle_inputs();
        check("ajmp_pc", 32'(pc), 32'h3FF);
        repeat (2) step();
        check("ajmp_clr", 32'(clr_sgn), 32'd0);
        check("ajmp_hold_pc", 32'(pc), 32'h3FF);
        step();
        check("wrap_pc", 32'(pc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_pc_ctrl.md
Name: wb_pc_ctrl

Overview:
Writeback and program-flow controller consuming the EX/WB pipeline register outputs (result, dest, write_en, read, halt, jump fields). It owns the 8-entry register file, the program counter, load completion via a data-memory read handshake, and pipeline flush (clr_sgn) generation on jumps. It sits at the tail of the pipeline and drives decode (register reads) and fetch (pc, stall, clr_sgn).

Parameters:
A_BITS, 10, address / pc / jump-value width
D_BITS, 32, data width
FLUSH_CYCLES, 2, cycles clr_sgn stays high after a taken jump (1..15)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset, asynchronous, active-low
in_result  in  D_BITS  ALU result or load address (low A_BITS bits)
in_dest  in  3  destination register index
in_halt_op  in  1  halt instruction
in_jmp_op  in  1  jump instruction
in_jmp_relative_op  in  1  1 = pc-relative jump, 0 = absolute
in_jmp_val  in  A_BITS  jump target or two's-complement offset
in_read  in  1  instruction is a load
in_write_en  in  1  register write requested
mem_rd_req  out  1  data-memory read request (registered)
mem_rd_addr  out  A_BITS  read address (registered)
mem_rd_valid  in  1  read data valid
mem_rd_data  in  D_BITS  read data
rf_raddr_a  in  3  decode read port A address
rf_rdata_a  out  D_BITS  read port A data
rf_raddr_b  in  3  decode read port B address
rf_rdata_b  out  D_BITS  read port B data
pc  out  A_BITS  program counter
clr_sgn  out  1  pipeline flush
stall  out  1  upstream hold while a load is outstanding
halted  out  1  processor halted

Behaviour:
- Reset (async, nrst low): state RUN, pc=0, all 8 registers=0, mem_rd_req=0, mem_rd_addr=0, clr_sgn=0, stall=0, halted=0, flush counter=0. Reset mid-load or mid-flush aborts immediately; mem_rd_req drops asynchronously.
- States: RUN, LOAD_WAIT, FLUSH, HALT. clr_sgn = (state==FLUSH); stall = (state==LOAD_WAIT); halted = (state==HALT). All three are decoded from registered state.
- RUN: inputs sampled each rising edge. Priority: halt > jmp > load > plain write.
  - halt: next state HALT; pc held; no register write.
  - jmp: pc <= jmp_relative ? pc + jmp_val (sign-extended, mod 2^A_BITS) : jmp_val. If in_write_en, rf[in_dest] <= in_result in the same edge; in_read is ignored. Next state FLUSH, counter <= FLUSH_CYCLES-1.
  - load (in_read & in_write_en): mem_rd_req <= 1, mem_rd_addr <= in_result[A_BITS-1:0], dest latched; next state LOAD_WAIT; pc held.
  - in_read without in_write_en: treated as a no-op; pc+1.
  - write only: rf[in_dest] <= in_result; pc <= pc+1.
  - no op: pc <= pc+1 (wraps from 2^A_BITS-1 to 0).
- LOAD_WAIT: mem_rd_req and mem_rd_addr held; in_* ignored; pc held.
  - On edge with mem_rd_valid=1: rf[latched dest] <= mem_rd_data, mem_rd_req <= 0, next state RUN.
  - Valid in the first LOAD_WAIT cycle allowed (minimum 1-cycle load). mem_rd_valid outside LOAD_WAIT is ignored.
- FLUSH: clr_sgn high; in_* ignored; pc held. Counter decrements each cycle; at 0, next state RUN. clr_sgn is high exactly FLUSH_CYCLES cycles, starting the cycle after the jump edge.
- HALT: terminal until reset; all state frozen; clr_sgn=0, mem_rd_req=0.
- Register reads: combinational, with write-first bypass. If a write to the same index occurs at the coming edge (RUN write or LOAD_WAIT completion), rf_rdata_* returns the write data. Register 0 is an ordinary writable register.

Test Plan:
- Reset then 5 idle cycles -> pc=5, clr_sgn=0, stall=0, rf_rdata_a(raddr 3)=0.
- Write in_dest=3, in_result=0xDEADBEEF, write_en=1 with rf_raddr_a=3 -> rf_rdata_a=0xDEADBEEF combinationally in the same cycle (bypass) and after the edge; pc+1.
- pc=20, relative jump in_jmp_val=-4 (0x3FC) -> pc=16 next cycle; clr_sgn high 2 cycles; pc stays 16; a write presented during flush is not performed.
- Load addr 0x055, dest 5; mem_rd_valid after 3 cycles with data 0x12345678 -> mem_rd_req=1/addr 0x055 for 3 cycles, stall=1 for 3 cycles, then rf[5]=0x12345678, pc resumes incrementing.
- halt and jmp asserted together -> halted=1, pc unchanged, no clr_sgn, holds 10 cycles; nrst pulse -> pc=0, RUN.
- nrst asserted during LOAD_WAIT -> mem_rd_req=0 immediately, state RUN; absolute jump to 0x3FF followed by idle -> pc wraps to 0.
